multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Main sequencer for the multi-cycle RISC-V datapath.
- Walks each instruction through IF/ID/EX/MEM/WB.
- Drives PC/IR write enables, memory strobes, ALU operand selects and the 2-bit alu_ctrl_op consumed by the ALU control unit.
- Handles variable-latency memory via a ready handshake, halts on ECALL, and counts retired instructions.

Parameters:
- STATE_W, 3, width of state_out encoding.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset (0 = reset asserted).
- inst  input  32  current IR contents; opcode=inst[6:0].
- bcond  input  1  branch-taken flag from ALU, valid in EX for BRANCH.
- halt_cond  input  1  x17==10, sampled in ID for ECALL.
- mem_ready  input  1  memory completes current read/write this cycle.
- pc_write  output  1  PC load enable.
- pc_source  output  1  0=ALU result, 1=ALUOut register.
- ir_write  output  1  IR load enable.
- i_or_d  output  1  memory address: 0=PC, 1=ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_to_reg  output  1  RF write data: 0=ALUOut, 1=MDR.
- reg_write  output  1  RF write enable.
- alu_src_a  output  1  0=PC, 1=rs1 (A reg).
- alu_src_b  output  2  00=rs2 (B reg), 01=const 4, 10=imm.
- alu_ctrl_op  output  2  00=add, 01=I-type funct3 decode, 10=R-type decode, 11=opcode decode (branch compare).
- is_halted  output  1  sticky halt flag.
- state_out  output  STATE_W  current state.
- inst_count  output  CNT_W  retired instructions.

Behaviour:
- States (encoding): IF=0, ID=1, EX=2, MEM=3, WB=4, BR=5, HALT=6.
- Registered: state, is_halted, inst_count. All other outputs are combinational from state, opcode, bcond, mem_ready, halt_cond.
- Reset (reset==0, async): state=IF, is_halted=0, inst_count=0.
- Default for every output not named below: 0.
- IF:
  - mem_read=1, i_or_d=0.
  - If mem_ready: ir_write=1 and go to ID.
  - Otherwise stay in IF, with ir_write=0 and mem_read held.
- ID:
  - alu_src_a=0, alu_src_b=01, alu_ctrl_op=00 (ALUOut<=PC+4).
  - ECALL (1110011) with halt_cond=1: go to HALT.
  - ECALL with halt_cond=0, or unknown opcode: pc_write=1, pc_source=0, go to IF (treated as NOP).
  - All other opcodes: go to EX.
- EX, by opcode:
  - ARITHMETIC (0110011): a=1, b=00, op=10; go to WB.
  - ARITHMETIC_IMM (0010011): a=1, b=10, op=01; go to WB.
  - LOAD (0000011) / STORE (0100011): a=1, b=10, op=00; go to MEM.
  - BRANCH (1100011): a=1, b=00, op=11.
    - bcond=1: go to BR.
    - bcond=0: pc_write=1, pc_source=1 (ALUOut still holds PC+4); go to IF.
  - JAL (1101111): a=0, b=10, op=00, reg_write=1, mem_to_reg=0 (writes ALUOut=PC+4), pc_write=1, pc_source=0; go to IF.
  - JALR (1100111): same as JAL but a=1.
- BR: a=0, b=10, op=00, pc_write=1, pc_source=0; go to IF.
- MEM: i_or_d=1; a=0, b=01, op=00 (ALU recomputes PC+4).
  - LOAD: mem_read=1; when mem_ready, go to WB.
  - STORE: mem_write=1; when mem_ready, pc_write=1, pc_source=0, go to IF.
  - Without mem_ready: hold all strobes and stay in MEM.
- WB: reg_write=1, mem_to_reg=(opcode==LOAD); a=0, b=01, op=00, pc_write=1, pc_source=0; go to IF.
- HALT: is_halted=1, sticky. All strobes 0; no exit except reset.
- inst_count:
  - Increments by 1 in every cycle where pc_write=1, and on the ID->HALT transition.
  - Wraps modulo 2^CNT_W.
- Reset mid-operation (e.g. MEM with mem_write=1): strobes drop immediately (combinational from state); no further PC or RF update.
- Cycle counts with mem_ready=1 always:
  - R/I: 4 cycles.
  - LOAD: 5.
  - STORE: 4.
  - Branch not taken: 3; taken: 4.
  - JAL/JALR: 3.
  - NOP/ECALL: 2.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1 -> states IF,ID,EX,WB; EX: alu_ctrl_op=10, alu_src_b=00; WB: reg_write=1, mem_to_reg=0, pc_write=1; inst_count 0->1.
- lw (0x0000A183), mem_ready low for 3 cycles in MEM -> mem_read/i_or_d held in MEM for 4 cycles, then WB with mem_to_reg=1; total 8 cycles.
- beq (0x00208463): bcond=1 -> BR asserts pc_write, pc_source=0, alu_src_b=10; bcond=0 -> pc_write in EX with pc_source=1, 3 cycles.
- ECALL (0x00000073): halt_cond=1 -> HALT after ID, is_halted=1 stays high for 20 cycles, inst_count +1; with halt_cond=0 -> pc_write in ID, back to IF.
- sw (0x0020A023) with reset pulled low during MEM while mem_write=1 -> mem_write=0 in the same cycle, state_out=0, inst_count=0, is_halted=0.
- jal (0x008000EF) -> EX asserts reg_write=1, mem_to_reg=0, pc_write=1, alu_src_a=0, alu_src_b=10; next state IF.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_fsm
//  Purpose  : Main sequencer for the multi-cycle RISC-V datapath. Steps each
//             instruction through IF/ID/EX/MEM/WB, drives the datapath enables
//             and selects, handles memory wait states, halts on ECALL and
//             counts retired instructions.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_control_fsm #(
  parameter int STATE_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,       // active-low, asynchronous
  input  logic [31:0]        inst,
  input  logic               bcond,
  input  logic               halt_cond,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_source,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_ctrl_op,
  output logic               is_halted,
  output logic [STATE_W-1:0] state_out,
  output logic [CNT_W-1:0]   inst_count
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_BR   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  state_t     state;
  state_t     next_state;
  logic [6:0] opcode;
  logic       known_op;
  logic       halt_entry;
  logic       unused_inst;

  assign opcode      = inst[6:0];
  assign unused_inst = ^inst[31:7];

  // Opcodes that proceed to EX; ECALL and anything unrecognised stop in ID.
  assign known_op = (opcode inside {OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
                                    OP_BRANCH, OP_JAL, OP_JALR});

  // ECALL with x17==10 retires into the halt state.
  assign halt_entry = (state == S_ID) && (opcode == OP_ECALL) && halt_cond;

  assign state_out = STATE_W'(state);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IF;
    end else begin
      state <= next_state;
    end
  end

  // Sticky halt flag and retired-instruction counter (wraps naturally).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_halted  <= 1'b0;
      inst_count <= '0;
    end else begin
      if (halt_entry) begin
        is_halted <= 1'b1;
      end
      if (pc_write || halt_entry) begin
        inst_count <= inst_count + CNT_W'(1);
      end
    end
  end

  // Next-state and control decode; everything defaults to inactive.
  always_comb begin
    next_state  = state;
    pc_write    = 1'b0;
    pc_source   = 1'b0;
    ir_write    = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_ctrl_op = 2'b00;

    case (state)
      S_IF: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          next_state = S_ID;
        end
      end

      S_ID: begin
        // ALUOut <= PC + 4 while decoding.
        alu_src_b = 2'b01;
        if ((opcode == OP_ECALL) && halt_cond) begin
          next_state = S_HALT;
        end else if ((opcode == OP_ECALL) || !known_op) begin
          pc_write   = 1'b1;
          next_state = S_IF;
        end else begin
          next_state = S_EX;
        end
      end

      S_EX: begin
        case (opcode)
          OP_ARITH: begin
            alu_src_a   = 1'b1;
            alu_ctrl_op = 2'b10;
            next_state  = S_WB;
          end
          OP_ARITH_IMM: begin
            alu_src_a   = 1'b1;
            alu_src_b   = 2'b10;
            alu_ctrl_op = 2'b01;
            next_state  = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            next_state = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a   = 1'b1;
            alu_ctrl_op = 2'b11;
            if (bcond) begin
              next_state = S_BR;
            end else begin
              // Not taken: ALUOut still holds PC+4 from ID.
              pc_write   = 1'b1;
              pc_source  = 1'b1;
              next_state = S_IF;
            end
          end
          OP_JAL, OP_JALR: begin
            // Link register receives ALUOut (PC+4); PC takes the target.
            alu_src_a  = (opcode == OP_JALR);
            alu_src_b  = 2'b10;
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            next_state = S_IF;
          end
          default: begin
            next_state = S_IF;
          end
        endcase
      end

      S_MEM: begin
        i_or_d    = 1'b1;
        alu_src_b = 2'b01;
        if (opcode == OP_LOAD) begin
          mem_read = 1'b1;
          if (mem_ready) begin
            next_state = S_WB;
          end
        end else begin
          mem_write = 1'b1;
          if (mem_ready) begin
            pc_write   = 1'b1;
            next_state = S_IF;
          end
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OP_LOAD);
        alu_src_b  = 2'b01;
        pc_write   = 1'b1;
        next_state = S_IF;
      end

      S_BR: begin
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        next_state = S_IF;
      end

      S_HALT: begin
        next_state = S_HALT;
      end

      default: begin
        next_state = S_IF;
      end
    endcase
  end

endmodule
`default_nettype wire
